cpu_run_ctrl: RTL and testbench

Run-control sequencer for the 4-bit CPU core. It owns the core's clock-enable and reset. It loads the 16×8 program memory from a byte stream while holding the core in reset, then runs the core at a divided tick rate, single-steps it, or halts it on command or at a breakpoint. It sits between the board-level command inputs (buttons/UART decoder) and the CPU core plus program RAM.

---
 rtl/cpu_run_ctrl_pkg.sv | 14 +
 rtl/cpu_run_ctrl_if.sv | 40 ++++
 rtl/cpu_run_ctrl_tick_gen.sv | 29 ++
 rtl/cpu_run_ctrl.sv | 109 ++++++++++
 tb/tb_cpu_run_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the 4-bit CPU run-control block.
package lib_cpu;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    LOAD = 2'd3
  } CTRL_STATE;

  localparam int PROG_DEPTH = 16;
  localparam int PTR_W      = $clog2(PROG_DEPTH);

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Command, program-stream, breakpoint and core/RAM-side signals of the run controller.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
);
  import lib_cpu::*;

  logic             cmd_run;
  logic             cmd_halt;
  logic             cmd_step;
  logic             cmd_load;
  logic             prog_valid;
  logic [7:0]       prog_data;
  logic             prog_ready;
  logic             bp_en;
  logic [3:0]       bp_addr;
  logic [3:0]       cpu_addr;
  logic             cpu_en;
  logic             cpu_n_reset;
  logic             mem_we;
  logic [3:0]       mem_waddr;
  logic [7:0]       mem_wdata;
  CTRL_STATE        state;
  logic [CNT_W-1:0] instr_count;

  // The run controller drives the core and RAM side.
  modport master (
    input  cmd_run, cmd_halt, cmd_step, cmd_load,
    input  prog_valid, prog_data, bp_en, bp_addr, cpu_addr,
    output prog_ready, cpu_en, cpu_n_reset,
    output mem_we, mem_waddr, mem_wdata, state, instr_count
  );

  modport slave (
    output cmd_run, cmd_halt, cmd_step, cmd_load,
    output prog_valid, prog_data, bp_en, bp_addr, cpu_addr,
    input  prog_ready, cpu_en, cpu_n_reset,
    input  mem_we, mem_waddr, mem_wdata, state, instr_count
  );

endinterface

// File: rtl/cpu_run_ctrl_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter; tick marks the terminal count, clear holds it at 0.
module tick_gen #(
  parameter int TICK_DIV = 12_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = !clear && (cnt == TERM);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: loads program RAM with the core held in reset, then runs,
// single-steps or halts the core; all outputs are registered.
module cpu_run_ctrl
  import lib_cpu::*;
#(
  parameter int TICK_DIV = 12_000_000,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            reset,
  cpu_run_ctrl_if.master bus
);

  CTRL_STATE        state;
  CTRL_STATE        next_state;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;
  logic             first_tick;
  logic             tick;
  logic             pulse;
  logic             beat;
  logic             bp_hit;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state != RUN),
    .tick  (tick)
  );

  // prog_ready is only ever high in LOAD, so it already qualifies the handshake.
  assign beat   = bus.prog_valid && bus.prog_ready;
  assign bp_hit = bus.bp_en && (bus.cpu_addr == bus.bp_addr) && !first_tick;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    pulse      = 1'b0;
    case (state)
      HALT: begin
        if (bus.cmd_load) begin
          next_state = LOAD;
        end else if (bus.cmd_halt) begin
          next_state = HALT;
        end else if (bus.cmd_step) begin
          next_state = STEP;
          pulse      = 1'b1;
        end else if (bus.cmd_run) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (bus.cmd_load) begin
          next_state = LOAD;
        end else if (bus.cmd_halt) begin
          next_state = HALT;
        end else if (tick) begin
          if (bp_hit) next_state = HALT;
          else        pulse      = 1'b1;
        end
      end
      STEP: next_state = HALT;
      LOAD: begin
        if (bus.cmd_halt || (beat && ptr == PTR_W'(PROG_DEPTH - 1))) next_state = HALT;
      end
      default: next_state = HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= HALT;
      first_tick      <= 1'b0;
      ptr             <= '0;
      count           <= '0;
      bus.cpu_en      <= 1'b0;
      bus.cpu_n_reset <= 1'b0;
      bus.prog_ready  <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_waddr   <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      state           <= next_state;
      bus.cpu_en      <= pulse;
      bus.cpu_n_reset <= (next_state != LOAD);
      bus.prog_ready  <= (next_state == LOAD);
      bus.mem_we      <= beat;
      if (beat) begin
        bus.mem_waddr <= ptr;
        bus.mem_wdata <= bus.prog_data;
      end

      // Outside LOAD the pointer rests at 0, which also covers the clear on entry and on abort.
      if (next_state != LOAD) ptr <= '0;
      else if (beat)          ptr <= ptr + 1'b1;

      // A run resumed from a breakpoint must execute its first instruction unconditionally.
      if (state == HALT && next_state == RUN) first_tick <= 1'b1;
      else if (pulse)                         first_tick <= 1'b0;

      if (state != LOAD && next_state == LOAD) count <= '0;
      else if (pulse && count != '1)           count <= count + 1'b1;
    end
  end

  assign bus.state       = state;
  assign bus.instr_count = count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with TICK_DIV = 4 and a tiny core model advancing ip per cpu_en.
module tb_cpu_run_ctrl;
  import lib_cpu::*;

  localparam int TICK_DIV = 4;
  localparam int CNT_W    = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cpu_run_ctrl_if #(.CNT_W(CNT_W)) bus ();

  cpu_run_ctrl #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Core model: ip is reset by cpu_n_reset (or by the bench) and advances on each cpu_en.
  logic [3:0] ip;
  logic       ip_clr = 1'b0;
  always @(posedge clk) begin
    if (ip_clr || !bus.cpu_n_reset) ip <= 4'd0;
    else if (bus.cpu_en)            ip <= ip + 4'd1;
  end
  assign bus.cpu_addr = ip;

  typedef struct {
    logic [3:0] cmd;        // {load, halt, step, run}
    CTRL_STATE  exp_state;
    logic       exp_en;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cmd(input logic [3:0] c);
    bus.cmd_load = c[3];
    bus.cmd_halt = c[2];
    bus.cmd_step = c[1];
    bus.cmd_run  = c[0];
  endtask

  task automatic pulse_cmd(input logic [3:0] c);
    set_cmd(c);
    cyc(1);
    set_cmd(4'b0000);
  endtask

  initial begin
    int         pulses;
    int         halt_at;
    logic       en_seen;
    logic [7:0] b;

    vecs[0] = '{4'b0000, HALT, 1'b0};
    vecs[1] = '{4'b0001, RUN,  1'b0};
    vecs[2] = '{4'b0010, STEP, 1'b1};
    vecs[3] = '{4'b0100, HALT, 1'b0};
    vecs[4] = '{4'b1000, LOAD, 1'b0};
    vecs[5] = '{4'b1111, LOAD, 1'b0};
    vecs[6] = '{4'b0111, HALT, 1'b0};
    vecs[7] = '{4'b0011, STEP, 1'b1};
    vecs[8] = '{4'b0101, HALT, 1'b0};

    set_cmd(4'b0000);
    bus.prog_valid = 1'b0;
    bus.prog_data  = 8'h00;
    bus.bp_en      = 1'b0;
    bus.bp_addr    = 4'd0;

    // Reset values and release.
    cyc(2);
    check("rst_state",       bus.state,       HALT);
    check("rst_cpu_n_reset", bus.cpu_n_reset, 0);
    check("rst_cpu_en",      bus.cpu_en,      0);
    check("rst_prog_ready",  bus.prog_ready,  0);
    check("rst_instr_count", bus.instr_count, 0);
    reset = 1'b0;
    check("rel_n_reset_low", bus.cpu_n_reset, 0);
    cyc(1);
    check("rel_n_reset_high", bus.cpu_n_reset, 1);
    en_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      en_seen |= bus.cpu_en;
    end
    check("idle_cpu_en", en_seen, 0);
    check("idle_state",  bus.state, HALT);

    // Command priority from HALT.
    for (int v = 0; v < 9; v++) begin
      pulse_cmd(vecs[v].cmd);
      check($sformatf("prio%0d_state", v),   bus.state,       vecs[v].exp_state);
      check($sformatf("prio%0d_en", v),      bus.cpu_en,      vecs[v].exp_en);
      check($sformatf("prio%0d_ready", v),   bus.prog_ready,  vecs[v].exp_state == LOAD);
      check($sformatf("prio%0d_n_reset", v), bus.cpu_n_reset, vecs[v].exp_state != LOAD);
      if (vecs[v].exp_state == LOAD || vecs[v].exp_state == RUN) pulse_cmd(4'b0100);
      else if (vecs[v].exp_state == STEP) cyc(1);
    end

    // Full 16-byte load, back to back.
    pulse_cmd(4'b1000);
    check("load_state",   bus.state,       LOAD);
    check("load_ready",   bus.prog_ready,  1);
    check("load_n_reset", bus.cpu_n_reset, 0);
    for (int i = 0; i < 16; i++) begin
      bus.prog_valid = 1'b1;
      bus.prog_data  = 8'(i);
      cyc(1);
      check($sformatf("load%0d_we", i),    bus.mem_we,    1);
      check($sformatf("load%0d_addr", i),  bus.mem_waddr, i);
      check($sformatf("load%0d_data", i),  bus.mem_wdata, i);
      if (i < 15) check($sformatf("load%0d_n_reset", i), bus.cpu_n_reset, 0);
    end
    bus.prog_valid = 1'b0;
    check("load_done_state",   bus.state,       HALT);
    check("load_done_ready",   bus.prog_ready,  0);
    check("load_done_n_reset", bus.cpu_n_reset, 1);
    cyc(1);
    check("load_done_we", bus.mem_we, 0);

    // Free run: pulses at entry +4, +8, +12; halt at +13.
    pulse_cmd(4'b0001);
    check("run_state", bus.state, RUN);
    for (int k = 1; k <= 13; k++) begin
      cyc(1);
      check($sformatf("run_en_%0d", k), bus.cpu_en, (k % 4) == 0);
    end
    check("run_count", bus.instr_count, 3);
    pulse_cmd(4'b0100);
    check("run_halted", bus.state, HALT);

    // Breakpoint at ip 5, ip from 0.
    ip_clr = 1'b1;
    cyc(1);
    ip_clr = 1'b0;
    bus.bp_en   = 1'b1;
    bus.bp_addr = 4'd5;
    pulse_cmd(4'b0001);
    pulses  = 0;
    halt_at = 0;
    for (int c = 1; c <= 60; c++) begin
      cyc(1);
      if (bus.cpu_en) pulses++;
      if (bus.state == HALT) begin
        halt_at = c;
        break;
      end
    end
    check("bp_pulses",     pulses,  5);
    check("bp_halt_cycle", halt_at, 24);
    check("bp_ip",         ip,      5);

    // Resume from the breakpoint: first tick must not re-break.
    pulse_cmd(4'b0001);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      if (k <= 4) check($sformatf("resume_en_%0d", k), bus.cpu_en, k == 4);
      else        check("resume_state", bus.state, RUN);
    end
    pulse_cmd(4'b0100);
    check("resume_count", bus.instr_count, 9);

    // Single steps with the breakpoint on the current ip.
    pulse_cmd(4'b1000);
    pulse_cmd(4'b0100);
    check("step_pre_count", bus.instr_count, 0);
    for (int s = 0; s < 3; s++) begin
      bus.bp_addr = 4'(s);
      pulse_cmd(4'b0010);
      check($sformatf("step%0d_state", s), bus.state,  STEP);
      check($sformatf("step%0d_en", s),    bus.cpu_en, 1);
      cyc(1);
      check($sformatf("step%0d_back", s),  bus.state,  HALT);
      check($sformatf("step%0d_en_off", s), bus.cpu_en, 0);
    end
    check("step_count", bus.instr_count, 3);
    bus.bp_en = 1'b0;

    // Abort a load after 7 beats.
    pulse_cmd(4'b1000);
    for (int i = 0; i < 7; i++) begin
      b              = 8'hA0 + 8'(i);
      bus.prog_valid = 1'b1;
      bus.prog_data  = b;
      cyc(1);
    end
    check("abort_last_addr", bus.mem_waddr, 6);
    bus.prog_valid = 1'b0;
    pulse_cmd(4'b0100);
    check("abort_state",   bus.state,       HALT);
    check("abort_ready",   bus.prog_ready,  0);
    check("abort_n_reset", bus.cpu_n_reset, 1);
    bus.prog_valid = 1'b1;
    bus.prog_data  = 8'h33;
    en_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      en_seen |= bus.mem_we;
    end
    check("abort_no_we", en_seen, 0);
    bus.prog_valid = 1'b0;

    // Pointer restarted at 0 after the abort.
    pulse_cmd(4'b1000);
    bus.prog_valid = 1'b1;
    bus.prog_data  = 8'h5A;
    cyc(1);
    bus.prog_valid = 1'b0;
    check("reload_addr", bus.mem_waddr, 0);
    check("reload_data", bus.mem_wdata, 8'h5A);
    pulse_cmd(4'b0100);

    // Asynchronous reset in the middle of RUN.
    pulse_cmd(4'b0001);
    cyc(10);
    check("pre_rst_count", bus.instr_count, 2);
    reset = 1'b1;
    #1;
    check("arst_state",       bus.state,       HALT);
    check("arst_cpu_n_reset", bus.cpu_n_reset, 0);
    check("arst_cpu_en",      bus.cpu_en,      0);
    check("arst_prog_ready",  bus.prog_ready,  0);
    check("arst_mem_we",      bus.mem_we,      0);
    check("arst_mem_waddr",   bus.mem_waddr,   0);
    check("arst_mem_wdata",   bus.mem_wdata,   0);
    check("arst_instr_count", bus.instr_count, 0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("post_rst_n_reset", bus.cpu_n_reset, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
